// File: rtl/mac_pkg.sv
// Shared types, widths and helpers for the multiply-accumulate controller.
package mac_pkg;

  typedef enum logic {
    StAccum = 1'b0,
    StHold  = 1'b1
  } state_e;

  localparam int unsigned OPW   = 8;
  localparam int unsigned PRODW = 16;

  // Saturating increment; callers zero-extend to 32 bits and truncate the result.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
    return (cnt == max) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Accumulator adder: widened add of acc and product with overflow detect and clamp/wrap select.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W    = 24,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [PRODW-1:0] prod_i,
  input  logic             cout_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             ovf_o
);

  logic [ACC_W:0] sum;

  // Add one bit wider than the accumulator so the carry out is visible.
  always_comb begin
    sum   = {1'b0, acc_i} + (ACC_W + 1)'(prod_i);
    ovf_o = sum[ACC_W] | cout_i;
    if (ovf_o && SATURATE) begin
      acc_o = {ACC_W{1'b1}};
    end else begin
      acc_o = sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/mac_accum_8x8.sv
// Multiply-accumulate controller driving an external 8x8 multiplier; streams in operand pairs and
// presents the dot product, element count and sticky overflow once the last beat is accumulated.
module mac_accum_8x8
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W    = 24,
  parameter int unsigned COUNT_W  = 8,
  parameter bit          SATURATE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [OPW-1:0]     in_a_i,
  input  logic [OPW-1:0]     in_b_i,
  input  logic               in_last_i,
  output logic [OPW-1:0]     mul_a_o,
  output logic [OPW-1:0]     mul_b_o,
  input  logic [PRODW-1:0]   mul_prod_i,
  input  logic               mul_cout_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [ACC_W-1:0]   out_acc_o,
  output logic [COUNT_W-1:0] out_count_o,
  output logic               out_ovf_o
);

  state_e             state_q, state_d;
  logic               op_vld_q, op_last_q;
  logic [OPW-1:0]     mul_a_q, mul_b_q;
  logic [ACC_W-1:0]   acc_q, add_acc;
  logic [COUNT_W-1:0] count_q;
  logic               ovf_q, add_ovf;
  logic               in_xfer, out_xfer;

  assign in_xfer  = in_valid_i & in_ready_o;
  assign out_xfer = out_valid_o & out_ready_i;

  mac_sat_add #(
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .acc_i  (acc_q),
    .prod_i (mul_prod_i),
    .cout_i (mul_cout_i),
    .acc_o  (add_acc),
    .ovf_o  (add_ovf)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StAccum;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: enter HOLD once the last beat is accumulated, leave when the result is taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccum: if (op_vld_q && op_last_q) state_d = StHold;
      StHold:  if (out_ready_i) state_d = StAccum;
      default: state_d = StAccum;
    endcase
  end

  // Handshake outputs; the pending last beat blocks further input until the result is taken.
  always_comb begin
    in_ready_o  = (state_q == StAccum) && !(op_vld_q && op_last_q);
    out_valid_o = (state_q == StHold);
  end

  // Operand capture stage feeding the multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_vld_q  <= 1'b0;
      op_last_q <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
    end else begin
      op_vld_q <= in_xfer;
      if (in_xfer) begin
        op_last_q <= in_last_i;
        mul_a_q   <= in_a_i;
        mul_b_q   <= in_b_i;
      end
    end
  end

  // Accumulate the settled product one cycle after capture; clear when the result is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (op_vld_q) begin
      acc_q   <= add_acc;
      ovf_q   <= ovf_q | add_ovf;
      count_q <= COUNT_W'(sat_inc(32'(count_q), 32'({COUNT_W{1'b1}})));
    end else if (out_xfer) begin
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end
  end

  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign out_acc_o   = acc_q;
  assign out_count_o = count_q;
  assign out_ovf_o   = ovf_q;

endmodule

// File: tb/tb_mac_accum_8x8.sv
// Directed bench for mac_accum_8x8: one default instance plus two 16-bit instances (saturate, wrap)
// sharing the same input stream; the multiplier is modelled behaviourally.
module tb_mac_accum_8x8;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_last, out_ready, force_cout;
  logic [7:0] in_a, in_b;

  logic        rdy0, rdy1, rdy2, vld0, vld1, vld2;
  logic [7:0]  ma0, mb0, ma1, mb1, ma2, mb2;
  logic [15:0] mp0, mp1, mp2;
  logic [23:0] acc0;
  logic [15:0] acc1, acc2;
  logic [7:0]  cnt0, cnt1, cnt2;
  logic        ovf0, ovf1, ovf2;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  assign mp0 = 16'(ma0) * 16'(mb0);
  assign mp1 = 16'(ma1) * 16'(mb1);
  assign mp2 = 16'(ma2) * 16'(mb2);

  mac_accum_8x8 u_dut (
    .clk (clk), .rst (rst), .in_valid_i (in_valid), .in_ready_o (rdy0),
    .in_a_i (in_a), .in_b_i (in_b), .in_last_i (in_last), .mul_a_o (ma0), .mul_b_o (mb0),
    .mul_prod_i (mp0), .mul_cout_i (force_cout), .out_valid_o (vld0), .out_ready_i (out_ready),
    .out_acc_o (acc0), .out_count_o (cnt0), .out_ovf_o (ovf0)
  );

  mac_accum_8x8 #(.ACC_W (16), .COUNT_W (8), .SATURATE (1'b1)) u_sat (
    .clk (clk), .rst (rst), .in_valid_i (in_valid), .in_ready_o (rdy1),
    .in_a_i (in_a), .in_b_i (in_b), .in_last_i (in_last), .mul_a_o (ma1), .mul_b_o (mb1),
    .mul_prod_i (mp1), .mul_cout_i (1'b0), .out_valid_o (vld1), .out_ready_i (out_ready),
    .out_acc_o (acc1), .out_count_o (cnt1), .out_ovf_o (ovf1)
  );

  mac_accum_8x8 #(.ACC_W (16), .COUNT_W (8), .SATURATE (1'b0)) u_wrap (
    .clk (clk), .rst (rst), .in_valid_i (in_valid), .in_ready_o (rdy2),
    .in_a_i (in_a), .in_b_i (in_b), .in_last_i (in_last), .mul_a_o (ma2), .mul_b_o (mb2),
    .mul_prod_i (mp2), .mul_cout_i (1'b0), .out_valid_o (vld2), .out_ready_i (out_ready),
    .out_acc_o (acc2), .out_count_o (cnt2), .out_ovf_o (ovf2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one beat and return at the falling edge after it was accepted.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    for (n = 0; n < 50 && !rdy0; n++) @(negedge clk);
    if (n >= 50) check("send_timeout", 32'd1, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for a result, check it, then accept it and check the post-accept state.
  task automatic collect(input string tag, input logic [23:0] e_acc, input logic [7:0] e_cnt,
                         input logic e_ovf);
    int n;
    for (n = 0; n < 50 && !vld0; n++) @(negedge clk);
    if (n >= 50) check({tag, "_timeout"}, 32'd1, 32'd0);
    check({tag, "_acc"}, 32'(acc0), 32'(e_acc));
    check({tag, "_count"}, 32'(cnt0), 32'(e_cnt));
    check({tag, "_ovf"}, 32'(ovf0), 32'(e_ovf));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(vld0), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b0; force_cout = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(rdy0), 32'd1);
    check("rst_out_valid", 32'(vld0), 32'd0);
    check("rst_out_acc", 32'(acc0), 32'd0);
    check("rst_out_count", 32'(cnt0), 32'd0);
    check("rst_out_ovf", 32'(ovf0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: three back-to-back beats, out_ready held high; result lives exactly one cycle.
    out_ready = 1'b1;
    send(8'd3, 8'd4, 1'b0);
    send(8'd5, 8'd6, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    check("t1_valid_lat1", 32'(vld0), 32'd0);
    check("t1_ready_after_last", 32'(rdy0), 32'd0);
    @(negedge clk);
    check("t1_valid_lat2", 32'(vld0), 32'd1);
    check("t1_acc", 32'(acc0), 32'd65067);
    check("t1_count", 32'(cnt0), 32'd3);
    check("t1_ovf", 32'(ovf0), 32'd0);
    @(negedge clk);
    check("t1_valid_one_cycle", 32'(vld0), 32'd0);
    out_ready = 1'b0;

    // 2: 16-bit accumulators overflow; saturate clamps, wrap keeps the low bits.
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    @(negedge clk);
    check("t2_sat_valid", 32'(vld1), 32'd1);
    check("t2_sat_acc", 32'(acc1), 32'hFFFF);
    check("t2_sat_ovf", 32'(ovf1), 32'd1);
    check("t2_sat_count", 32'(cnt1), 32'd2);
    check("t2_wrap_acc", 32'(acc2), 32'hFC02);
    check("t2_wrap_ovf", 32'(ovf2), 32'd1);
    check("t2_wrap_count", 32'(cnt2), 32'd2);
    collect("t2_main", 24'd130050, 8'd2, 1'b0);

    // 3: single beat held against backpressure.
    send(8'd7, 8'd9, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 32'(vld0), 32'd1);
      check("t3_hold_acc", 32'(acc0), 32'd63);
      check("t3_hold_ready", 32'(rdy0), 32'd0);
      @(negedge clk);
    end
    collect("t3", 24'd63, 8'd1, 1'b0);
    check("t3_clr_acc", 32'(acc0), 32'd0);
    check("t3_clr_count", 32'(cnt0), 32'd0);
    check("t3_clr_ready", 32'(rdy0), 32'd1);

    // 4: gaps between beats.
    for (int i = 1; i <= 4; i++) begin
      send(8'(i), 8'(i), (i == 4));
      @(negedge clk);
    end
    collect("t4", 24'd30, 8'd4, 1'b0);

    // 5: asynchronous reset mid-vector discards the partial sum.
    send(8'd1, 8'd2, 1'b0);
    send(8'd3, 8'd4, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_acc", 32'(acc0), 32'd0);
    check("t5_rst_count", 32'(cnt0), 32'd0);
    check("t5_rst_mul_a", 32'(ma0), 32'd0);
    check("t5_rst_valid", 32'(vld0), 32'd0);
    check("t5_rst_ready", 32'(rdy0), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    send(8'd10, 8'd10, 1'b1);
    collect("t5", 24'd100, 8'd1, 1'b0);

    // 6: multiplier carry-out flags overflow for that vector only.
    force_cout = 1'b1;
    send(8'd2, 8'd3, 1'b1);
    @(negedge clk);
    force_cout = 1'b0;
    collect("t6_forced", 24'hFFFFFF, 8'd1, 1'b1);
    send(8'd2, 8'd3, 1'b1);
    collect("t6_next", 24'd6, 8'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

endmodule
